gmii_mdio_master: RTL and testbench
===================================

# gmii_mdio_master

MDIO management master that drives the MAC-side management signals of the GMII interface (MDIO_MDC, MDIO_O, MDIO_MAC_TN, MDIO_I) from a valid/ready command port.
- Supports Clause 22 and Clause 45 frames.
- MDC rate and preamble length are set by parameters.
- Read data and PHY-absent errors are returned on a valid/ready response port.
- Sits between the processing-system register bridge and the off-chip PHY's MDIO tristate buffer.

## Interface
- CLK_DIV, 25: clk cycles per MDC half-period; legal range 3..255; MDC = f_clk/(2*CLK_DIV).
- PREAMBLE_LEN, 32: number of preamble '1' bits; legal range 0..32; 0 = preamble suppression.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
- cmd_c45  input  1  1 = Clause 45 frame (ST=00), 0 = Clause 22 (ST=01).
- cmd_op  input  2  raw OP field: C22 01=write, 10=read; C45 00=address, 01=write, 11=read, 10=post-read-increment.
- cmd_phy  input  5  PHYAD / PRTAD.
- cmd_reg  input  5  REGAD / DEVAD.
- cmd_data  input  16  write data or C45 address; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid&rsp_ready.
- rsp_data  output  16  read data; 0x0000 for write and address frames.
- rsp_error  output  1  illegal command, or no PHY drove TA low.
- MDIO_MDC  output  1  management clock.
- MDIO_O  output  1  serial data to PHY.
- MDIO_MAC_TN  output  1  tristate enable: 1 = release/receive, 0 = drive.
- MDIO_I  input  1  serial data from PHY (asynchronous).

## Operation
- FSM states: IDLE, PRE, HDR, TA, DATA, RSP.
- IDLE: cmd_ready=1.
  - Legal command: latch all fields, go to PRE. If PREAMBLE_LEN=0, go to HDR instead.
  - Illegal command (cmd_c45=0 with op 00 or 11): no frame; go to RSP with rsp_error=1 and rsp_data=0.
- PRE: drives PREAMBLE_LEN bits of '1'.
- HDR: drives 14 bits, MSB first: ST(2), OP(2), PHY(5), REG(5).
- TA (2 bits):
  - Write and address frames drive 1,0.
  - Read frames (OP 10 in C22; 11 or 10 in C45): MDIO_MAC_TN=1 for both TA bits. The sampled second TA bit must be 0, otherwise rsp_error=1.
- DATA (16 bits, MSB first):
  - Writes drive cmd_data.
  - Reads keep TN=1 and shift in the sampled bits. On error, data is still shifted in, so a floating-high bus returns 0xFFFF.
- RSP: rsp_valid=1 with data and error held stable until rsp_ready. Then go to IDLE.
- cmd_ready=0 in every state except IDLE, so only one transaction is outstanding.
- Idle/reset values: MDIO_MDC=0, MDIO_O=1, MDIO_MAC_TN=1, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_error=0.
- MDIO_I passes through a 2-flop synchroniser before sampling.
- rst asserted in any state: outputs take their reset values on the next clk edge; the in-flight frame and any pending response are discarded.

## Timing
- A = the cycle in which cmd_valid&cmd_ready is seen.
- Bit k (k=0..N-1, N=PREAMBLE_LEN+32) occupies cycles A+1+2k*CLK_DIV through A+(2k+2)*CLK_DIV.
  - MDC is 0 for the first CLK_DIV cycles of each bit and 1 for the last CLK_DIV cycles.
  - MDIO_O and MDIO_MAC_TN change only on bit boundaries, i.e. with the MDC falling edge, giving CLK_DIV cycles of setup and hold around the MDC rise.
- MDIO_I (synchronised) is sampled in the last cycle of each bit. The PHY's value must therefore be stable at least 2 clk cycles before the MDC falling edge.
- Legal command: rsp_valid rises at cycle A+1+N*2*CLK_DIV; MDC is 0 from that cycle on.
- Illegal command: rsp_valid rises at A+1.
- cmd_ready rises the cycle after the rsp handshake. With rsp_ready tied high, back-to-back frames are separated by 2 cycles.

## Test plan
- CLK_DIV=3, PREAMBLE_LEN=32. C22 write phy=1 reg=0 data=0x1140 -> MDIO_O serialises 32×'1', 01 01 00001 00000 10 0001000101000000, with TN=0 throughout; rsp_valid at A+385 with rsp_data=0x0000, rsp_error=0.
- C22 read phy=3 reg=2; PHY model drives TA-low then 0x0141 on MDC rising edges -> TN=1 from TA onward; rsp_data=0x0141, rsp_error=0.
- C22 read with MDIO_I held at 1 (no PHY) -> rsp_data=0xFFFF, rsp_error=1, frame length unchanged.
- C45 address (op=00, prt=5, dev=1, data=0x0010), then C45 read (op=11) -> header ST bits are 00; read returns the model's value; PREAMBLE_LEN=0 build starts at HDR and rsp arrives at A+193.
- cmd_c45=0, op=00 -> cmd_ready low, rsp_valid at A+1 with rsp_error=1; MDC stays 0 and TN stays 1 throughout.
- Hold rsp_ready=0 for 20 cycles after a read -> rsp stable and cmd_ready=0 during hold. Assert rst mid-DATA of the next frame -> next cycle MDC=0, MDIO_O=1, TN=1, rsp_valid=0, cmd_ready=1.

Source files
------------

// File: rtl/gmii_mdio_master.sv
// gmii_mdio_master: Clause 22 / Clause 45 MDIO management master.
// Accepts one command on a valid/ready port, serialises the frame on
// MDIO_MDC/MDIO_O/MDIO_MAC_TN and returns read data / error on a response port.
module gmii_mdio_master #(
  parameter int CLK_DIV      = 25,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        MDIO_MDC,
  output logic        MDIO_O,
  output logic        MDIO_MAC_TN,
  input  logic        MDIO_I
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  // Last cycle of the MDC-low half and last cycle of the whole bit.
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;          // cycle within the current bit
  logic [5:0]        bit_cnt_q, bit_cnt_d;  // bit within the current state
  logic [31:0]       tx_sr_q, tx_sr_d;      // MSB is the frame bit on the wire
  logic [15:0]       rx_sr_q, rx_sr_d;
  logic              is_read_q, is_read_d;
  logic              ta_err_q, ta_err_d;
  logic              mdc_q, mdc_d;
  logic              mdo_q, mdo_d;
  logic              tn_q, tn_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic [1:0]        sync_q, sync_d;

  logic              mdi_s;
  logic              cmd_illegal;
  logic              cmd_is_read;
  logic [31:0]       cmd_frame;

  assign mdi_s       = sync_q[1];
  assign cmd_illegal = !cmd_c45 && (cmd_op == 2'b00 || cmd_op == 2'b11);
  assign cmd_is_read = cmd_c45 ? cmd_op[1] : (cmd_op == 2'b10);
  // ST, OP, PHYAD, REGAD, write turnaround, data: everything after the preamble.
  assign cmd_frame   = {1'b0, !cmd_c45, cmd_op, cmd_phy, cmd_reg, 2'b10, cmd_data};

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so the block never infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    is_read_d   = is_read_q;
    ta_err_d    = ta_err_q;
    mdc_d       = mdc_q;
    mdo_d       = mdo_q;
    tn_d        = tn_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    sync_d      = {sync_q[0], MDIO_I};

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_illegal) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_data_d  = 16'h0000;
          end else begin
            tx_sr_d   = cmd_frame;
            is_read_d = cmd_is_read;
            ta_err_d  = 1'b0;
            rx_sr_d   = 16'h0000;
            cnt_d     = '0;
            bit_cnt_d = 6'd0;
            mdc_d     = 1'b0;
            tn_d      = 1'b0;
            if (PREAMBLE_LEN == 0) begin
              state_d = S_HDR;
              mdo_d   = cmd_frame[31];
            end else begin
              state_d = S_PRE;
              mdo_d   = 1'b1;
            end
          end
        end
      end

      S_PRE, S_HDR, S_TA, S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_RISE) begin
          mdc_d = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          // Bit boundary: sample the PHY, then set up the next bit with MDC falling.
          cnt_d     = '0;
          mdc_d     = 1'b0;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (is_read_q && state_q == S_TA && bit_cnt_q[0]) begin
            ta_err_d = mdi_s;
          end
          if (is_read_q && state_q == S_DATA) begin
            rx_sr_d = {rx_sr_q[14:0], mdi_s};
          end
          if (state_q != S_PRE) begin
            tx_sr_d = tx_sr_q << 1;
          end

          case (state_q)
            S_PRE:   if (bit_cnt_q == PRE_LAST) begin state_d = S_HDR;  bit_cnt_d = 6'd0; end
            S_HDR:   if (bit_cnt_q == 6'd13)    begin state_d = S_TA;   bit_cnt_d = 6'd0; end
            S_TA:    if (bit_cnt_q == 6'd1)     begin state_d = S_DATA; bit_cnt_d = 6'd0; end
            S_DATA:  if (bit_cnt_q == 6'd15)    begin state_d = S_RSP;  bit_cnt_d = 6'd0; end
            default: ;
          endcase

          if (state_d == S_RSP) begin
            mdo_d       = 1'b1;
            tn_d        = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = is_read_q ? rx_sr_d : 16'h0000;
            rsp_error_d = ta_err_q;
          end else if (state_d == S_PRE) begin
            mdo_d = 1'b1;
            tn_d  = 1'b0;
          end else if (is_read_q && (state_d == S_TA || state_d == S_DATA)) begin
            // Bus released to the PHY from the turnaround onward.
            mdo_d = 1'b1;
            tn_d  = 1'b1;
          end else begin
            mdo_d = tx_sr_d[31];
            tn_d  = 1'b0;
          end
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = 16'h0000;
          rsp_error_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State, datapath and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= 6'd0;
      tx_sr_q     <= 32'h0;
      rx_sr_q     <= 16'h0;
      is_read_q   <= 1'b0;
      ta_err_q    <= 1'b0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b1;
      tn_q        <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0;
      rsp_error_q <= 1'b0;
      // Synchroniser resets to the idle (pulled-up) bus level.
      sync_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      is_read_q   <= is_read_d;
      ta_err_q    <= ta_err_d;
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      tn_q        <= tn_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      sync_q      <= sync_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign MDIO_MDC    = mdc_q;
  assign MDIO_O      = mdo_q;
  assign MDIO_MAC_TN = tn_q;

endmodule

// File: tb/tb_gmii_mdio_master.sv
// tb_gmii_mdio_master: table-driven and randomised frames against a bit-level
// model of the MDIO frame, plus reset and preamble-suppression sequences.
module tb_gmii_mdio_master;

  localparam int D   = 3;
  localparam int PRE = 32;
  localparam int N   = PRE + 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic        cmd_c45 = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_phy = 5'd0, cmd_reg = 5'd0;
  logic [15:0] cmd_data = 16'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [15:0] rsp_data;
  logic        mdc, mdo, mtn, mdi = 1'b1;

  // Second instance built without preamble.
  logic        cmd_valid_0 = 1'b0, cmd_ready_0;
  logic        rsp_valid_0, rsp_ready_0 = 1'b0, rsp_error_0;
  logic [15:0] rsp_data_0;
  logic        mdc_0, mdo_0, mtn_0, mdi_0 = 1'b1;

  gmii_mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(PRE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_c45(cmd_c45), .cmd_op(cmd_op),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .MDIO_MDC(mdc), .MDIO_O(mdo), .MDIO_MAC_TN(mtn), .MDIO_I(mdi)
  );

  gmii_mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(0)) dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid_0), .cmd_ready(cmd_ready_0), .cmd_c45(cmd_c45), .cmd_op(cmd_op),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready_0), .rsp_data(rsp_data_0), .rsp_error(rsp_error_0),
    .MDIO_MDC(mdc_0), .MDIO_O(mdo_0), .MDIO_MAC_TN(mtn_0), .MDIO_I(mdi_0)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit        c45;
    bit [1:0]  op;
    bit [4:0]  phy;
    bit [4:0]  rg;
    bit [15:0] data;
    bit        present;
    bit [15:0] val;
    int        hold;
    bit [15:0] exp_data;
    bit        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame model: PREAMBLE ones, then ST OP PHY REG TA DATA, MSB first.
  function automatic bit exp_bit(input int pre, input int k, input bit c45, input bit [1:0] op,
                                 input bit [4:0] phy, input bit [4:0] rg, input bit [15:0] data);
    bit [31:0] f;
    f = {(c45 ? 2'b00 : 2'b01), op, phy, rg, 2'b10, data};
    if (k < pre) return 1'b1;
    return f[31 - (k - pre)];
  endfunction

  function automatic bit op_is_read(input bit c45, input bit [1:0] op);
    return c45 ? (op == 2'b11 || op == 2'b10) : (op == 2'b10);
  endfunction

  function automatic bit op_is_illegal(input bit c45, input bit [1:0] op);
    return !c45 && (op == 2'b00 || op == 2'b11);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " mdc"}, mdc, 1'b0);
    check({tag, " mdo"}, mdo, 1'b1);
    check({tag, " tn"}, mtn, 1'b1);
    check({tag, " cmd_ready"}, cmd_ready, 1'b1);
    check({tag, " rsp_valid"}, rsp_valid, 1'b0);
    check({tag, " rsp_data"}, rsp_data, 16'h0);
    check({tag, " rsp_error"}, rsp_error, 1'b0);
  endtask

  // One transaction on the main instance; rst_bit >= 0 aborts with reset mid-bit.
  task automatic run_frame(input string tag, input vec_t v, input int rst_bit);
    bit rd;
    bit ill;
    bit eb;
    int waited;
    rd  = op_is_read(v.c45, v.op);
    ill = op_is_illegal(v.c45, v.op);
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 1000) begin
      tick();
      waited++;
    end
    check({tag, " ready wait"}, cmd_ready, 1'b1);
    if (cmd_ready !== 1'b1) return;

    cmd_valid = 1'b1;
    cmd_c45   = v.c45;
    cmd_op    = v.op;
    cmd_phy   = v.phy;
    cmd_reg   = v.rg;
    cmd_data  = v.data;
    tick();
    // Scramble the command bus: the frame must use the latched fields.
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_phy   = 5'($urandom);
    cmd_reg   = 5'($urandom);
    cmd_data  = 16'($urandom);
    check({tag, " cmd_ready low"}, cmd_ready, 1'b0);

    if (!ill) begin
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < 2 * D; j++) begin
          if (k == rst_bit && j == D) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            mdi = 1'b1;
            check_idle({tag, " after rst"});
            tick();
            tick();
            check({tag, " rst no resume mdc"}, mdc, 1'b0);
            check({tag, " rst no resume rsp"}, rsp_valid, 1'b0);
            return;
          end
          // PHY model: changes MDIO_I on MDC rise during TA/DATA of reads.
          if (j == D && rd && k >= PRE + 14) begin
            if (!v.present || k == PRE + 14) mdi = 1'b1;
            else if (k == PRE + 15)           mdi = 1'b0;
            else                              mdi = v.val[15 - (k - PRE - 16)];
          end
          eb = exp_bit(PRE, k, v.c45, v.op, v.phy, v.rg, v.data);
          check($sformatf("%s b%0d c%0d mdc", tag, k, j), mdc, (j >= D));
          if (rd && k >= PRE + 14) begin
            check($sformatf("%s b%0d c%0d tn", tag, k, j), mtn, 1'b1);
          end else begin
            check($sformatf("%s b%0d c%0d tn", tag, k, j), mtn, 1'b0);
            check($sformatf("%s b%0d c%0d mdo", tag, k, j), mdo, eb);
          end
          if (k == N - 1 && j == 2 * D - 1) check({tag, " rsp early"}, rsp_valid, 1'b0);
          tick();
        end
      end
      mdi = 1'b1;
    end

    check({tag, " rsp_valid"}, rsp_valid, 1'b1);
    check({tag, " rsp_data"}, rsp_data, v.exp_data);
    check({tag, " rsp_error"}, rsp_error, v.exp_err);
    check({tag, " rsp mdc"}, mdc, 1'b0);
    check({tag, " rsp tn"}, mtn, 1'b1);
    check({tag, " rsp mdo"}, mdo, 1'b1);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      check($sformatf("%s hold%0d valid", tag, h), rsp_valid, 1'b1);
      check($sformatf("%s hold%0d data", tag, h), rsp_data, v.exp_data);
      check($sformatf("%s hold%0d err", tag, h), rsp_error, v.exp_err);
      check($sformatf("%s hold%0d ready", tag, h), cmd_ready, 1'b0);
      check($sformatf("%s hold%0d mdc", tag, h), mdc, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " post rsp_valid"}, rsp_valid, 1'b0);
    check({tag, " post cmd_ready"}, cmd_ready, 1'b1);
    check({tag, " post rsp_data"}, rsp_data, 16'h0);
  endtask

  initial begin
    vec_t r;
    //           c45  op     phy  reg  data      pres val       hold exp_data  exp_err
    vecs[0] = '{1'b0, 2'b01, 5'd1, 5'd0, 16'h1140, 1'b1, 16'h0000, 0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 2'b10, 5'd3, 5'd2, 16'h0000, 1'b1, 16'h0141, 1, 16'h0141, 1'b0};
    vecs[2] = '{1'b0, 2'b10, 5'd3, 5'd2, 16'h0000, 1'b0, 16'h0000, 0, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b1, 2'b00, 5'd5, 5'd1, 16'h0010, 1'b1, 16'h0000, 0, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 2'b11, 5'd5, 5'd1, 16'h0000, 1'b1, 16'hBEEF, 2, 16'hBEEF, 1'b0};
    vecs[5] = '{1'b1, 2'b10, 5'd9, 5'd3, 16'h0000, 1'b1, 16'h1234, 0, 16'h1234, 1'b0};
    vecs[6] = '{1'b1, 2'b01, 5'd31, 5'd30, 16'hA55A, 1'b1, 16'h0000, 0, 16'h0000, 1'b0};
    vecs[7] = '{1'b0, 2'b00, 5'd1, 5'd1, 16'h1234, 1'b1, 16'h0000, 3, 16'h0000, 1'b1};
    vecs[8] = '{1'b0, 2'b11, 5'd2, 5'd2, 16'h4321, 1'b1, 16'h0000, 0, 16'h0000, 1'b1};
    vecs[9] = '{1'b0, 2'b10, 5'd7, 5'd4, 16'h0000, 1'b1, 16'h8001, 20, 16'h8001, 1'b0};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset dut0 ready", cmd_ready_0, 1'b1);
    check("reset dut0 tn", mtn_0, 1'b1);

    for (int i = 0; i < 10; i++) run_frame($sformatf("vec%0d", i), vecs[i], -1);

    // Randomised commands scored against the frame rules.
    for (int i = 0; i < 8; i++) begin
      r.c45     = 1'($urandom);
      r.op      = 2'($urandom);
      r.phy     = 5'($urandom);
      r.rg      = 5'($urandom);
      r.data    = 16'($urandom);
      r.present = ($urandom_range(0, 3) != 0);
      r.val     = 16'($urandom);
      r.hold    = $urandom_range(0, 3);
      if (op_is_illegal(r.c45, r.op)) begin
        r.exp_data = 16'h0000;
        r.exp_err  = 1'b1;
      end else if (op_is_read(r.c45, r.op)) begin
        r.exp_data = r.present ? r.val : 16'hFFFF;
        r.exp_err  = !r.present;
      end else begin
        r.exp_data = 16'h0000;
        r.exp_err  = 1'b0;
      end
      run_frame($sformatf("rnd%0d", i), r, -1);
    end

    // Reset in the middle of the data phase of a write.
    run_frame("rstmid", '{1'b0, 2'b01, 5'd4, 5'd6, 16'hC3C3, 1'b1, 16'h0, 0, 16'h0, 1'b0},
              PRE + 16 + 5);

    // Preamble-suppressed build: frame starts with ST, response at A+193.
    cmd_c45     = 1'b0;
    cmd_op      = 2'b01;
    cmd_phy     = 5'd2;
    cmd_reg     = 5'd4;
    cmd_data    = 16'hA5C3;
    check("nopre ready", cmd_ready_0, 1'b1);
    cmd_valid_0 = 1'b1;
    tick();
    cmd_valid_0 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 2 * D; j++) begin
        if (j == D + 1) begin
          check($sformatf("nopre b%0d mdo", k), mdo_0,
                exp_bit(0, k, 1'b0, 2'b01, 5'd2, 5'd4, 16'hA5C3));
          check($sformatf("nopre b%0d tn", k), mtn_0, 1'b0);
          check($sformatf("nopre b%0d mdc", k), mdc_0, 1'b1);
        end
        if (k == 31 && j == 2 * D - 1) check("nopre rsp early", rsp_valid_0, 1'b0);
        tick();
      end
    end
    check("nopre rsp_valid", rsp_valid_0, 1'b1);
    check("nopre rsp_data", rsp_data_0, 16'h0);
    check("nopre rsp_error", rsp_error_0, 1'b0);
    rsp_ready_0 = 1'b1;
    tick();
    rsp_ready_0 = 1'b0;
    check("nopre post ready", cmd_ready_0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
